// File: rtl/axi_timer_slave.sv
// rtl/axi_timer_slave.sv - AXI4 responder exposing a RISC-V machine timer (mtime/mtimecmp)
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   aw_* / aw_valid, aw_ready  write address channel (id, addr, len, size, burst)
//   w_* / w_valid, w_ready     write data channel (32-bit data, 4-bit strobe, last)
//   b_* / b_valid, b_ready     write response channel (id echo, resp)
//   ar_* / ar_valid, ar_ready  read address channel (id, addr, len, size, burst)
//   r_* / r_valid, r_ready     read data channel (id echo, data, resp, last)
//   b_user, r_user             driven 0
//   irq_o                      registered machine timer interrupt level
module axi_timer_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 2,
  parameter int unsigned AXI_USER_WIDTH = 2,
  parameter int unsigned PRESCALE       = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]                aw_len,
  input  logic [2:0]                aw_size,
  input  logic [1:0]                aw_burst,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [31:0]               w_data,
  input  logic [3:0]                w_strb,
  input  logic                      w_last,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic [AXI_ID_WIDTH-1:0]   b_id,
  output logic [1:0]                b_resp,
  output logic                      b_valid,
  input  logic                      b_ready,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]                ar_len,
  input  logic [2:0]                ar_size,
  input  logic [1:0]                ar_burst,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  output logic [AXI_ID_WIDTH-1:0]   r_id,
  output logic [31:0]               r_data,
  output logic [1:0]                r_resp,
  output logic                      r_last,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [AXI_USER_WIDTH-1:0] b_user,
  output logic [AXI_USER_WIDTH-1:0] r_user,
  output logic                      irq_o
);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e                  state_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [4:0]              off_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic                    fixed_q;
  logic                    werr_q;
  logic [63:0]             mtime_q;
  logic [63:0]             mtimecmp_q;
  logic                    en_q;
  logic [PW-1:0]           presc_q;
  logic                    b_valid_q;
  logic [1:0]              b_resp_q;
  logic                    r_valid_q;
  logic [31:0]             r_data_q;
  logic [1:0]              r_resp_q;
  logic                    r_last_q;
  logic                    irq_q;

  logic                    w_hs;
  logic                    last_beat;
  logic [4:0]              next_off;
  logic [4:0]              rd_off;
  logic [31:0]             rd_data;
  logic                    rd_err;
  logic                    tick;
  logic [PW-1:0]           presc_d;
  logic [63:0]             mtime_inc;
  logic [63:0]             mtime_d;
  logic [63:0]             mtimecmp_d;
  logic                    en_d;
  logic                    wr_err;
  logic                    werr_d;
  logic                    unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Write wins the IDLE arbitration; ready is only offered to a pending valid.
  assign aw_ready = rst_ni && (state_q == IDLE) && aw_valid;
  assign ar_ready = rst_ni && (state_q == IDLE) && ar_valid && !aw_valid;
  assign w_ready  = rst_ni && (state_q == WDATA);
  assign w_hs     = w_ready && w_valid;

  // 5-bit offset arithmetic wraps INCR bursts inside the 32-byte window.
  assign next_off  = fixed_q ? off_q : off_q + 5'd4;
  assign last_beat = (cnt_q == len_q);
  // First read beat is looked up from the AR address, later beats from the advanced offset.
  assign rd_off    = (state_q == IDLE) ? ar_addr[4:0] : next_off;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_off[4:2])
      3'd0:    rd_data = mtime_q[31:0];
      3'd1:    rd_data = mtime_q[63:32];
      3'd2:    rd_data = mtimecmp_q[31:0];
      3'd3:    rd_data = mtimecmp_q[63:32];
      3'd4:    rd_data = {31'b0, en_q};
      default: rd_err  = 1'b1;
    endcase
  end

  // Bus writes merge onto the already-incremented mtime so unwritten bytes keep counting.
  always_comb begin
    tick       = en_q && (presc_q == PW'(PRESCALE - 1));
    presc_d    = presc_q;
    if (en_q) presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_inc  = mtime_q + {63'b0, tick};
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    wr_err     = 1'b0;
    if (w_hs) begin
      case (off_q[4:2])
        3'd0:    mtime_d[31:0]     = merge(mtime_inc[31:0], w_data, w_strb);
        3'd1:    mtime_d[63:32]    = merge(mtime_inc[63:32], w_data, w_strb);
        3'd2:    mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], w_data, w_strb);
        3'd3:    mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], w_data, w_strb);
        3'd4:    if (w_strb[0]) en_d = w_data[0];
        default: wr_err = 1'b1;
      endcase
    end
    // The beat counter ends the burst; a w_last that disagrees only poisons the response.
    werr_d = werr_q || wr_err || (w_last != last_beat);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      off_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      fixed_q    <= 1'b0;
      werr_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b1;
      presc_q    <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      r_last_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      irq_q      <= en_q && (mtime_q >= mtimecmp_q);
      case (state_q)
        IDLE: begin
          if (aw_ready) begin
            id_q    <= aw_id;
            off_q   <= aw_addr[4:0];
            len_q   <= aw_len;
            fixed_q <= (aw_burst == 2'b00);
            cnt_q   <= '0;
            werr_q  <= 1'b0;
            state_q <= WDATA;
          end else if (ar_ready) begin
            id_q      <= ar_id;
            off_q     <= ar_addr[4:0];
            len_q     <= ar_len;
            fixed_q   <= (ar_burst == 2'b00);
            cnt_q     <= '0;
            r_valid_q <= 1'b1;
            r_data_q  <= rd_data;
            r_resp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_last_q  <= (ar_len == 8'd0);
            state_q   <= RDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            if (last_beat) begin
              b_valid_q <= 1'b1;
              b_resp_q  <= werr_d ? RESP_SLVERR : RESP_OKAY;
              state_q   <= WRESP;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              off_q  <= next_off;
              werr_q <= werr_d;
            end
          end
        end
        WRESP: begin
          if (b_ready) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RDATA: begin
          if (r_ready) begin
            if (r_last_q) begin
              r_valid_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              cnt_q    <= cnt_q + 8'd1;
              off_q    <= next_off;
              r_data_q <= rd_data;
              r_resp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
              r_last_q <= ((cnt_q + 8'd1) == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign b_id    = id_q;
  assign b_resp  = b_resp_q;
  assign b_valid = b_valid_q;
  assign r_id    = id_q;
  assign r_data  = r_data_q;
  assign r_resp  = r_resp_q;
  assign r_last  = r_last_q;
  assign r_valid = r_valid_q;
  assign b_user  = '0;
  assign r_user  = '0;
  assign irq_o   = irq_q;

  // Upper address bits, size fields and sub-word offset bits carry no meaning here.
  assign unused_bits = ^{aw_addr[AXI_ADDR_WIDTH-1:5], ar_addr[AXI_ADDR_WIDTH-1:5],
                         aw_size, ar_size, rd_off[1:0]};

endmodule

// File: tb/tb_axi_timer_slave.sv
// tb/tb_axi_timer_slave.sv - directed self-checking bench for axi_timer_slave
module tb_axi_timer_slave;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [1:0]  aw_id, ar_id, b_id, r_id, b_user, r_user;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready, irq_o;

  always #5 clk = ~clk;

  axi_timer_slave #(
    .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(2), .AXI_USER_WIDTH(2), .PRESCALE(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready), .b_user(b_user), .r_user(r_user), .irq_o(irq_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          w_cyc;
  logic        irq_w0;
  logic [31:0] wdata_a [8];
  logic [31:0] rdata_a [8];
  logic [1:0]  rresp_a [8];
  logic        rlast_a [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [1:0] id, input logic [3:0] strb,
                           input logic last_bad, input logic [1:0] exp_resp);
    int n;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd2; aw_burst = burst; aw_valid = 1'b1;
    #1;
    n = 0;
    while (!aw_ready && n < 20) begin @(posedge clk); #2; n++; end
    check({tag, " aw_ready"}, aw_ready, 1'b1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data = wdata_a[i]; w_strb = strb; w_last = (i == int'(len)) ^ last_bad; w_valid = 1'b1;
      #1;
      check({tag, " w_ready"}, w_ready, 1'b1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
    w_cyc = cyc; irq_w0 = irq_o;
    #1;
    n = 0;
    while (!b_valid && n < 20) begin @(posedge clk); #2; n++; end
    check({tag, " b_valid"}, b_valid, 1'b1);
    check({tag, " b_resp"}, b_resp, exp_resp);
    check({tag, " b_id"}, b_id, id);
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [1:0] id);
    int n;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd2; ar_burst = burst; ar_valid = 1'b1;
    #1;
    n = 0;
    while (!ar_ready && n < 20) begin @(posedge clk); #2; n++; end
    check({tag, " ar_ready"}, ar_ready, 1'b1);
    @(posedge clk); #1;
    ar_valid = 1'b0; r_ready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      #1;
      n = 0;
      while (!r_valid && n < 20) begin @(posedge clk); #2; n++; end
      check({tag, " r_valid on time"}, r_valid && (n == 0), 1'b1);
      check({tag, " r_id"}, r_id, id);
      rdata_a[i] = r_data; rresp_a[i] = r_resp; rlast_a[i] = r_last;
      @(posedge clk); #1;
    end
    r_ready = 1'b0;
  endtask

  initial begin
    int          k;
    int          ce;
    logic [31:0] v;
    rst_ni = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
    r_ready = 1'b0;
    for (int i = 0; i < 8; i++) wdata_a[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst aw_ready", aw_ready, 1'b0);
    check("rst ar_ready", ar_ready, 1'b0);
    check("rst w_ready", w_ready, 1'b0);
    check("rst b_valid", b_valid, 1'b0);
    check("rst r_valid", r_valid, 1'b0);
    check("rst irq", irq_o, 1'b0);
    check("rst r_data", r_data, 32'h0);
    check("rst b_resp", b_resp, 2'b00);
    check("rst r_last", r_last, 1'b0);
    rst_ni = 1'b1;

    // Reset values of mtimecmp and CTRL
    axi_read("rd cmp lo", 32'h08, 8'd0, INCR, 2'd2);
    check("rd cmp lo data", rdata_a[0], 32'hFFFF_FFFF);
    check("rd cmp lo resp", rresp_a[0], OKAY);
    check("rd cmp lo last", rlast_a[0], 1'b1);
    axi_read("rd cmp hi", 32'h0C, 8'd0, INCR, 2'd2);
    check("rd cmp hi data", rdata_a[0], 32'hFFFF_FFFF);
    check("rd cmp hi resp", rresp_a[0], OKAY);
    check("rd cmp hi last", rlast_a[0], 1'b1);
    axi_read("rd ctrl", 32'h10, 8'd0, INCR, 2'd1);
    check("rd ctrl data", rdata_a[0], 32'h1);
    check("irq after reset", irq_o, 1'b0);

    // Compare match timing: irq rises 21 edges after mtime is cleared with cmp = 20
    wdata_a[0] = 32'd20;
    axi_write("wr cmp lo", 32'h08, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    wdata_a[0] = 32'd0;
    axi_write("wr cmp hi", 32'h0C, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    axi_write("wr mtime lo", 32'h00, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    ce = w_cyc;
    axi_write("wr mtime hi", 32'h04, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    check("irq low before match", irq_o, 1'b0);
    k = 0;
    while (!irq_o && k < 60) begin @(posedge clk); #1; k++; end
    check("irq rise delay", 64'(cyc - ce), 64'd21);
    wdata_a[0] = 32'd0;
    axi_write("wr ctrl off", 32'h10, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    check("irq at ctrl write edge", irq_w0, 1'b1);
    check("irq after ctrl off", irq_o, 1'b0);
    axi_read("frz a", 32'h00, 8'd0, INCR, 2'd0);
    v = rdata_a[0];
    repeat (5) @(posedge clk);
    #1;
    axi_read("frz b", 32'h00, 8'd0, INCR, 2'd0);
    check("mtime frozen", rdata_a[0], v);
    wdata_a[0] = 32'd1;
    axi_write("wr ctrl on", 32'h10, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);

    // INCR write burst then read burst
    wdata_a[0] = 32'd5; wdata_a[1] = 32'd0; wdata_a[2] = 32'd100; wdata_a[3] = 32'd0;
    axi_write("burst w", 32'h00, 8'd3, INCR, 2'd2, 4'hF, 1'b0, OKAY);
    check("burst single b", b_valid, 1'b0);
    axi_read("burst r", 32'h00, 8'd3, INCR, 2'd0);
    check("burst r lo counting", (rdata_a[0] >= 32'd5) && (rdata_a[0] < 32'd40), 1'b1);
    check("burst r hi", rdata_a[1], 32'd0);
    check("burst r cmp lo", rdata_a[2], 32'd100);
    check("burst r cmp hi", rdata_a[3], 32'd0);
    check("burst r lasts", {rlast_a[0], rlast_a[1], rlast_a[2], rlast_a[3]}, 4'b0001);
    check("burst r resps", {rresp_a[0], rresp_a[1], rresp_a[2], rresp_a[3]}, 8'h00);

    // Simultaneous AW and AR: write wins, read sees the written value
    aw_id = 2'd3; aw_addr = 32'h08; aw_len = 8'd0; aw_size = 3'd2; aw_burst = INCR; aw_valid = 1'b1;
    ar_id = 2'd1; ar_addr = 32'h08; ar_len = 8'd0; ar_size = 3'd2; ar_burst = INCR; ar_valid = 1'b1;
    #1;
    check("arb aw_ready", aw_ready, 1'b1);
    check("arb ar_ready idle", ar_ready, 1'b0);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_data = 32'h55; w_strb = 4'hF; w_last = 1'b1; w_valid = 1'b1;
    #1;
    check("arb w_ready", w_ready, 1'b1);
    check("arb ar_ready wdata", ar_ready, 1'b0);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
    #1;
    check("arb b_valid", b_valid, 1'b1);
    check("arb b_resp", b_resp, OKAY);
    check("arb b_id", b_id, 2'd3);
    check("arb ar_ready wresp", ar_ready, 1'b0);
    @(posedge clk); #1;
    b_ready = 1'b0;
    #1;
    check("arb ar_ready after b", ar_ready, 1'b1);
    @(posedge clk); #1;
    ar_valid = 1'b0; r_ready = 1'b1;
    #1;
    check("arb r_valid", r_valid, 1'b1);
    check("arb r_data", r_data, 32'h55);
    check("arb r_id", r_id, 2'd1);
    check("arb r_last", r_last, 1'b1);
    @(posedge clk); #1;
    r_ready = 1'b0;

    // Unmapped offsets, w_last mismatch, wrap and FIXED bursts
    axi_read("rd 0x14", 32'h14, 8'd0, INCR, 2'd0);
    check("rd 0x14 resp", rresp_a[0], SLVERR);
    check("rd 0x14 data", rdata_a[0], 32'h0);
    wdata_a[0] = 32'hFFFF_FFFF;
    axi_write("wr 0x18", 32'h18, 8'd0, INCR, 2'd1, 4'hF, 1'b0, SLVERR);
    axi_read("rd after 0x18", 32'h08, 8'd2, INCR, 2'd0);
    check("cmp lo kept", rdata_a[0], 32'h55);
    check("cmp hi kept", rdata_a[1], 32'h0);
    check("ctrl kept", rdata_a[2], 32'h1);
    axi_read("wrap", 32'h1C, 8'd1, INCR, 2'd0);
    check("wrap resp0", rresp_a[0], SLVERR);
    check("wrap data0", rdata_a[0], 32'h0);
    check("wrap resp1", rresp_a[1], OKAY);
    check("wrap lasts", {rlast_a[0], rlast_a[1]}, 2'b01);
    axi_read("fixed", 32'h08, 8'd2, FIXED, 2'd3);
    check("fixed data", {rdata_a[0], rdata_a[1], rdata_a[2]}, {32'h55, 32'h55, 32'h55});
    check("fixed lasts", {rlast_a[0], rlast_a[1], rlast_a[2]}, 3'b001);
    wdata_a[0] = 32'h0;
    axi_write("wlast bad", 32'h0C, 8'd0, INCR, 2'd0, 4'hF, 1'b1, SLVERR);

    // Byte strobes and the 32-bit carry, with the counter stopped
    wdata_a[0] = 32'h0;
    axi_write("carry ctrl off", 32'h10, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    axi_write("carry hi", 32'h04, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    axi_write("carry lo clr", 32'h00, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    wdata_a[0] = 32'hFFFF_ABFF;
    axi_write("strb lo", 32'h00, 8'd0, INCR, 2'd0, 4'b0010, 1'b0, OKAY);
    axi_read("strb rd", 32'h00, 8'd0, INCR, 2'd0);
    check("strb merge", rdata_a[0], 32'h0000_AB00);
    wdata_a[0] = 32'hFFFF_FFFF;
    axi_write("carry lo", 32'h00, 8'd0, INCR, 2'd0, 4'hF, 1'b0, OKAY);
    axi_read("carry pre", 32'h00, 8'd1, INCR, 2'd0);
    check("carry pre lo", rdata_a[0], 32'hFFFF_FFFF);
    check("carry pre hi", rdata_a[1], 32'h0);
    wdata_a[0] = 32'h1; wdata_a[1] = 32'h0;
    axi_write("one tick", 32'h10, 8'd1, FIXED, 2'd0, 4'hF, 1'b0, OKAY);
    axi_read("carry post", 32'h00, 8'd1, INCR, 2'd0);
    check("carry post lo", rdata_a[0], 32'h0);
    check("carry post hi", rdata_a[1], 32'h1);

    // Reset during a stalled read
    ar_id = 2'd2; ar_addr = 32'h00; ar_len = 8'd0; ar_burst = INCR; ar_valid = 1'b1;
    #1;
    check("abort ar_ready", ar_ready, 1'b1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    #1;
    check("abort r_valid before", r_valid, 1'b1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("abort r_valid after", r_valid, 1'b0);
    check("abort b_valid", b_valid, 1'b0);
    rst_ni = 1'b1;
    axi_read("post rst mtime", 32'h00, 8'd1, INCR, 2'd0);
    check("post rst mtime lo", rdata_a[0] < 32'd20, 1'b1);
    check("post rst mtime hi", rdata_a[1], 32'h0);
    axi_read("post rst cmp", 32'h08, 8'd2, INCR, 2'd0);
    check("post rst cmp lo", rdata_a[0], 32'hFFFF_FFFF);
    check("post rst ctrl", rdata_a[2], 32'h1);
    check("post rst irq", irq_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
